// File: rtl/cic_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cic_pkg
// Brief    : Width helper and sign extension shared by the CIC interpolator
//            and decimator.
// Revision : 1.0
// ============================================================================
package cic_pkg;

    // Widest internal word either CIC block may elaborate with.
    localparam int C_MAX_W = 128;

    // Full Hogenauer growth: every stage adds log2(R) bits (M = 1).
    function automatic int cic_out_width(input int isz, input int stages, input int stg_gsz);
        return isz + stages * stg_gsz;
    endfunction

    // Replicates bit w-1 of v into every higher bit position.
    function automatic logic [C_MAX_W-1:0] sign_ext(input logic [C_MAX_W-1:0] v, input int w);
        logic [C_MAX_W-1:0] r;
        r = v;
        for (int b = 0; b < C_MAX_W; b++) begin
            if (b >= w) begin
                r[b] = v[w-1];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_comb_stage.sv
`default_nettype none
// ============================================================================
// Module   : cic_comb_stage
// Brief    : One comb register pair; on enable diff takes i_din and dly takes
//            the previous diff.
// Revision : 1.0
// ============================================================================
module cic_comb_stage #(
    parameter int W = 22
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_diff,
    output logic [W-1:0] o_dly
);
    logic [W-1:0] diff_q, diff_d;
    logic [W-1:0] dly_q, dly_d;

    always_comb begin
        diff_d = diff_q;
        dly_d  = dly_q;
        if (i_en) begin
            diff_d = i_din;
            dly_d  = diff_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q <= '0;
            dly_q  <= '0;
        end else begin
            diff_q <= diff_d;
            dly_q  <= dly_d;
        end
    end

    assign o_diff = diff_q;
    assign o_dly  = dly_q;

endmodule
`default_nettype wire

// File: rtl/cic_decimator.sv
`default_nettype none
// ============================================================================
// Module   : cic_decimator
// Brief    : N-stage CIC decimator by 2^STG_GSZ with full-precision output.
// Revision : 1.0
// ============================================================================
module cic_decimator
    import cic_pkg::*;
#(
    parameter int  NUM_STAGES = 3,
    parameter int  STG_GSZ    = 8,
    parameter int  ISZ        = 16,
    localparam int OSZ        = cic_out_width(ISZ, NUM_STAGES, STG_GSZ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic signed [ISZ-1:0] in,
    output logic                  out_valid,
    output logic signed [OSZ-1:0] out
);
    localparam logic [STG_GSZ-1:0] C_CNT_MAX = '1;

    // The comb pipeline must drain before the next decimation strobe.
    if ((1 << STG_GSZ) < NUM_STAGES + 2) begin : g_chk_ratio
        $error("cic_decimator: 2^STG_GSZ must be >= NUM_STAGES+2");
    end
    if (OSZ > C_MAX_W) begin : g_chk_width
        $error("cic_decimator: output width exceeds C_MAX_W");
    end

    logic [OSZ-1:0]          in_ext;
    logic [OSZ-1:0]          integ_q [NUM_STAGES];
    logic [OSZ-1:0]          integ_d [NUM_STAGES];
    logic [STG_GSZ-1:0]      cnt_q, cnt_d;
    logic [NUM_STAGES+1:0]   comb_en_q, comb_en_d;
    logic [OSZ-1:0]          diff [NUM_STAGES+1];
    logic [OSZ-1:0]          dly  [NUM_STAGES+1];
    logic [OSZ-1:0]          out_q, out_d;
    logic                    out_valid_q, out_valid_d;

    assign in_ext = OSZ'(sign_ext(C_MAX_W'(in), ISZ));

    // Integrators wrap modulo 2^OSZ on purpose; the combs cancel the overflow.
    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            integ_d[i] = integ_q[i];
        end
        cnt_d = cnt_q;
        if (in_valid) begin
            integ_d[0] = integ_q[0] + in_ext;
            for (int i = 1; i < NUM_STAGES; i++) begin
                integ_d[i] = integ_q[i] + integ_q[i-1];
            end
            cnt_d = cnt_q + STG_GSZ'(1);
        end
        comb_en_d   = {comb_en_q[NUM_STAGES:0], in_valid && (cnt_q == C_CNT_MAX)};
        out_valid_d = comb_en_q[NUM_STAGES+1];
        out_d       = comb_en_q[NUM_STAGES+1] ? diff[NUM_STAGES] : out_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                integ_q[i] <= '0;
            end
            cnt_q       <= '0;
            comb_en_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                integ_q[i] <= integ_d[i];
            end
            cnt_q       <= cnt_d;
            comb_en_q   <= comb_en_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Stage 0 samples the last integrator; stages 1..N form the comb cascade.
    for (genvar j = 0; j <= NUM_STAGES; j++) begin : g_comb
        logic [OSZ-1:0] stage_in;
        if (j == 0) begin : g_head
            assign stage_in = integ_q[NUM_STAGES-1];
        end else begin : g_tail
            assign stage_in = diff[j-1] - dly[j-1];
        end
        cic_comb_stage #(
            .W (OSZ)
        ) u_stage (
            .clk    (clk),
            .rst_n  (reset_n),
            .i_en   (comb_en_q[j]),
            .i_din  (stage_in),
            .o_diff (diff[j]),
            .o_dly  (dly[j])
        );
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_cic_decimator
// Brief    : Two decimators (R=4 and R=256) on one random stimulus stream,
//            compared against an arithmetic CIC reference model.
// Revision : 1.0
// ============================================================================
module tb_cic_decimator;
    localparam int N     = 3;
    localparam int R_A   = 4;
    localparam int R_B   = 256;
    localparam int OSZ_A = 22;
    localparam int OSZ_B = 40;
    localparam int LAT   = N + 2;

    logic                    clk      = 1'b0;
    logic                    reset_n  = 1'b0;
    logic                    in_valid = 1'b0;
    logic signed [15:0]      din      = '0;
    logic                    out_valid_a, out_valid_b;
    logic signed [OSZ_A-1:0] out_a;
    logic signed [OSZ_B-1:0] out_b;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint integ_m [2][N];
    longint prev_m  [2][N];
    int     cnt_m   [2];
    longint exp_a[$], exp_b[$], seen_a[$], seen_b[$];
    longint last_a, last_b;
    int     lat;

    always #5 clk = ~clk;

    cic_decimator #(.NUM_STAGES(N), .STG_GSZ(2), .ISZ(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in(din),
        .out_valid(out_valid_a), .out(out_a)
    );
    cic_decimator #(.NUM_STAGES(N), .STG_GSZ(8), .ISZ(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in(din),
        .out_valid(out_valid_b), .out(out_b)
    );

    task automatic check(input string tag, input longint got, input longint expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
        end
    endtask

    function automatic longint sx(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    // Reference: cascaded integrators per accepted sample, keep every R-th
    // value of the last one, then N first differences on the kept values.
    task automatic model_step(input int id, input longint x);
        longint nxt[N];
        longint v, d;
        nxt[0] = integ_m[id][0] + x;
        for (int i = 1; i < N; i++) nxt[i] = integ_m[id][i] + integ_m[id][i-1];
        for (int i = 0; i < N; i++) integ_m[id][i] = nxt[i];
        cnt_m[id]++;
        if (cnt_m[id] == ((id == 0) ? R_A : R_B)) begin
            cnt_m[id] = 0;
            v = integ_m[id][N-1];
            for (int j = 0; j < N; j++) begin
                d = v - prev_m[id][j];
                prev_m[id][j] = v;
                v = d;
            end
            if (id == 0) exp_a.push_back(sx(v, OSZ_A));
            else         exp_b.push_back(sx(v, OSZ_B));
        end
    endtask

    // Inputs change at posedge+1, so at negedge they are what the next posedge samples.
    always @(negedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                cnt_m[k] = 0;
                for (int i = 0; i < N; i++) begin
                    integ_m[k][i] = 0;
                    prev_m[k][i]  = 0;
                end
            end
            exp_a.delete(); exp_b.delete(); seen_a.delete(); seen_b.delete();
            last_a = 0; last_b = 0;
        end else begin
            if (out_valid_a) begin
                if (exp_a.size() == 0) check("a_spurious_pulse", 1, 0);
                else                   check("a_out", longint'(out_a), exp_a.pop_front());
                seen_a.push_back(longint'(out_a));
                last_a = longint'(out_a);
            end else begin
                check("a_hold", longint'(out_a), last_a);
            end
            if (out_valid_b) begin
                if (exp_b.size() == 0) check("b_spurious_pulse", 1, 0);
                else                   check("b_out", longint'(out_b), exp_b.pop_front());
                seen_b.push_back(longint'(out_b));
                last_b = longint'(out_b);
            end else begin
                check("b_hold", longint'(out_b), last_b);
            end
            if (in_valid) begin
                model_step(0, longint'(din));
                model_step(1, longint'(din));
            end
        end
    end

    task automatic send(input logic signed [15:0] x);
        @(posedge clk); #1;
        in_valid = 1'b1;
        din      = x;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset_n  = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
    endtask

    // Called right after the 4th send; counts cycles from the sampling edge.
    task automatic measure_latency(output int l);
        l = -1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (out_valid_a) begin
                l = k;
                break;
            end
        end
    endtask

    initial begin
        logic signed [15:0] x;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_a", longint'(out_a), 0);
        check("rst_valid_a", longint'(out_valid_a), 0);
        check("rst_out_b", longint'(out_b), 0);
        check("rst_valid_b", longint'(out_valid_b), 0);
        #2 reset_n = 1'b1;

        repeat (4) send(16'sd1);
        measure_latency(lat);
        check("latency", lat, LAT);
        idle(10);
        check("lat_pulses", seen_a.size(), 1);
        check("lat_first_out", seen_a[0], 4);

        do_reset();
        repeat (40) send(16'sd1);
        idle(12);
        check("dc1_pulses", seen_a.size(), 10);
        for (int i = 0; i < seen_a.size(); i++) begin
            if (i >= 3) begin
                check("dc1_settled", seen_a[i], 64);
            end else begin
                check("dc1_le64", longint'(seen_a[i] <= 64), 1);
                if (i > 0) check("dc1_nondecr", longint'(seen_a[i] >= seen_a[i-1]), 1);
            end
        end

        do_reset();
        repeat (40) send(-16'sd32768);
        idle(12);
        check("dcneg_settled", seen_a[$], -2097152);

        do_reset();
        for (int i = 0; i < 120; i++) begin
            send(16'sd5);
            idle($urandom_range(0, 4));
        end
        idle(12);
        check("duty_pulses", seen_a.size(), 30);
        check("duty_settled", seen_a[$], 320);

        // Abort a frame with cnt=2 while the comb pipeline is busy.
        for (int i = 0; i < 6; i++) send(16'($urandom_range(0, 65535)));
        @(posedge clk);
        check("pre_rst_out", longint'(out_a), 320);
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_out_a", longint'(out_a), 0);
        check("async_rst_valid_a", longint'(out_valid_a), 0);
        check("async_rst_out_b", longint'(out_b), 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (4) send(16'sd7);
        measure_latency(lat);
        check("post_rst_latency", lat, LAT);
        idle(10);
        check("post_rst_pulses", seen_a.size(), 1);
        check("post_rst_first", seen_a[0], 28);

        do_reset();
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 9) == 0) idle(1);
            if ($urandom_range(0, 7) == 0) x = ($urandom_range(0, 1) == 1) ? 16'sh7fff : 16'sh8000;
            else                           x = 16'($urandom_range(0, 65535));
            send(x);
        end
        idle(12);
        check("rand_pulses_a", seen_a.size(), 2500);
        check("rand_pulses_b", seen_b.size(), 39);
        check("rand_pending_a", exp_a.size(), 0);
        check("rand_pending_b", exp_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
